switch_debouncer: RTL and testbench

- Input-side conditioner for the board's slide switches and push buttons: the acquisition end of the switch→LED path.
- Each of N raw asynchronous switch lines is synchronized into the clock domain, then debounced.
- Outputs per channel: a clean stable level plus single-cycle rise/fall event pulses.
- Downstream logic (LED drivers, mode FSMs) consumes these outputs instead of raw pins.

---
 rtl/switch_debouncer.sv | 102 ++++++++++
 tb/tb_switch_debouncer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer feeding independent per-channel debouncers.
// Each channel emits a clean level plus single-cycle rise/fall pulses.
module switch_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CW              = 19
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (i_sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Accepting clears the count, so it can never pass CNT_LAST.
      stable_d = i_sync;
      cnt_d    = '0;
      rise_d   = i_sync;
      fall_d   = ~i_sync;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign o_stable = stable_q;
  assign o_rise   = rise_q;
  assign o_fall   = fall_q;
endmodule

module switch_debouncer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_switch,
  output logic [N-1:0] o_switch_stable,
  output logic [N-1:0] o_rise,
  output logic [N-1:0] o_fall
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = i_switch;
    sync2_d = sync1_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    switch_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CW             (CW)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sync  (sync2_q[g]),
      .o_stable(o_switch_stable[g]),
      .o_rise  (o_rise[g]),
      .o_fall  (o_fall[g])
    );
  end
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: window-based reference model checked
// every cycle, plus literal expectations at the key edges of each scenario.
module tb_switch_debouncer;
  localparam int N  = 4;
  localparam int DC = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sw;
  logic [N-1:0] stable, rise, fall;

  switch_debouncer #(.N(N), .DEBOUNCE_CYCLES(DC)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_switch       (sw),
    .o_switch_stable(stable),
    .o_rise         (rise),
    .o_fall         (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a level is accepted once the last DC synchronized samples
  // (raw samples delayed by two edges) all differ from the current level.
  logic [N-1:0] samp [0:DC+1];
  logic [N-1:0] m_stable, m_rise, m_fall;
  bit           cmp_en = 1'b0;

  initial begin
    for (int j = 0; j <= DC + 1; j++) samp[j] = '0;
    m_stable = '0; m_rise = '0; m_fall = '0;
  end

  always @(posedge clk) begin
    for (int j = DC + 1; j > 0; j--) samp[j] = samp[j-1];
    samp[0] = rst_n ? sw : '0;
    m_rise  = '0;
    m_fall  = '0;
    if (!rst_n) begin
      m_stable = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 2; j <= DC + 1; j++)
          if (samp[j][k] == m_stable[k]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[k] = ~m_stable[k];
          if (m_stable[k]) m_rise[k] = 1'b1;
          else             m_fall[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_stable", stable, rst_n ? m_stable : '0);
      check("model_rise",   rise,   rst_n ? m_rise   : '0);
      check("model_fall",   fall,   rst_n ? m_fall   : '0);
      check("rise_fall_excl", rise & fall, '0);
    end
  end

  // After the n-th edge expect the given outputs; no pulses before or after.
  task automatic expect_at(input string name, input int n,
                           input logic [N-1:0] es, input logic [N-1:0] er,
                           input logic [N-1:0] ef);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (i < n) check({name, "_early"}, rise | fall, '0);
    end
    check({name, "_stable"}, stable, es);
    check({name, "_rise"},   rise,   er);
    check({name, "_fall"},   fall,   ef);
    @(posedge clk); #1;
    check({name, "_pulse_end"}, rise | fall, '0);
  endtask

  task automatic drive_settle(input logic [N-1:0] v);
    @(negedge clk); sw = v;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = 4'b1111;
    cmp_en = 1'b1;
    #1;
    check("reset_async_stable", stable, '0);
    check("reset_async_pulses", rise | fall, '0);

    // 1: held in reset with all switches high, then release
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_hold_stable", stable, '0);
    end
    @(negedge clk); rst_n = 1'b1;
    expect_at("t1_release", 6, 4'b1111, 4'b1111, 4'b0000);

    // 2: clean press of bit 2 from all-zero
    drive_settle(4'b0000);
    @(negedge clk); sw = 4'b0100;
    expect_at("t2_press", 6, 4'b0100, 4'b0100, 4'b0000);

    // 3: bounce on bit 1 in 2-cycle phases, then settle high
    for (int p = 0; p < 4; p++) begin
      @(negedge clk); sw = (p % 2 == 0) ? 4'b0110 : 4'b0100;
      repeat (2) begin
        @(posedge clk); #1;
        check("t3_bounce_quiet", rise | fall, '0);
      end
    end
    @(negedge clk); sw = 4'b0110;
    expect_at("t3_settle", 6, 4'b0110, 4'b0010, 4'b0000);

    // 4: simultaneous multi-channel change
    drive_settle(4'b0101);
    @(posedge clk); #1;
    check("t4_pre_stable", stable, 4'b0101);
    @(negedge clk); sw = 4'b1010;
    expect_at("t4_multi", 6, 4'b1010, 4'b1010, 4'b0101);

    // 5: reset while bit 3 is mid-debounce
    drive_settle(4'b0001);
    @(negedge clk); sw = 4'b1001;
    @(posedge clk); @(posedge clk); #1;
    check("t5_pre_reset", stable, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_clear", stable, '0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    expect_at("t5_requalify", 6, 4'b1001, 4'b1001, 4'b0000);

    // 6: 3-cycle glitch on bit 0 from all-zero stable
    drive_settle(4'b0000);
    @(negedge clk); sw = 4'b0001;
    repeat (3) @(negedge clk);
    sw = 4'b0000;
    repeat (12) begin
      @(posedge clk); #1;
      check("t6_glitch_stable", stable, '0);
      check("t6_glitch_pulses", rise | fall, '0);
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
